biosignal_sample_writer: RTL and testbench
==========================================

// Module: biosignal_sample_writer
// PURPOSE
//   Consumes the live EMG/ECG words from adc_data_capture and commits them, at a fixed sample rate,
//   into two circular buffers in data RAM port B. Owns port B, so it also arbitrates VGA read
//   requests against sample writes.
//   Publishes per-channel write heads and a frame-complete pulse for the display and the CPU.
// PARAMETERS
//   SAMPLE_INTERVAL  175000  clock cycles per sample tick (200 Hz @ 35 MHz); legal range 4..2^18-1
//   BUF_DEPTH        640     entries per circular buffer (one per VGA column); 2..1023
//   EMG_BASE         12'h400 RAM word address of EMG buffer entry 0
//   ECG_BASE         12'h800 RAM word address of ECG buffer entry 0
// PORTS
//   clock         in   1   system clock (35 MHz)
//   reset         in   1   asynchronous, active-high
//   emg_in        in   32  current EMG conversion from adc_data_capture
//   ecg_in        in   32  current ECG conversion from adc_data_capture
//   vga_rd_req    in   1   VGA read request; held high until vga_rd_ack
//   vga_rd_addr   in   12  VGA read word address; stable while vga_rd_req is high
//   vga_rd_ack    out  1   request accepted this cycle (combinational)
//   vga_rd_valid  out  1   vga_rd_data valid; one cycle after vga_rd_ack
//   vga_rd_data   out  32  RAM read data (passthrough of ram_rdata)
//   ram_we        out  1   port B write enable
//   ram_addr      out  12  port B address
//   ram_wdata     out  32  port B write data
//   ram_rdata     in   32  port B read data; synchronous RAM, valid one cycle after ram_addr
//   emg_head      out  10  next EMG slot to be written, 0..BUF_DEPTH-1
//   ecg_head      out  10  next ECG slot to be written, 0..BUF_DEPTH-1
//   frame_done    out  1   one-cycle pulse; ECG head has just wrapped to 0
//   overrun_cnt   out  8   saturating count of ticks that arrived while a write was still pending
// BEHAVIOUR
//   Reset values
//   - Every output and internal register is 0 on reset: tick counter, heads, FSM=IDLE, pending flags.
//   - ram_we=0, vga_rd_valid=0, frame_done=0, overrun_cnt=0.
//   Sample tick
//   - tick_cnt counts 0..SAMPLE_INTERVAL-1 and wraps; tick=1 when tick_cnt==SAMPLE_INTERVAL-1.
//   - On tick, emg_in and ecg_in are registered into cap_emg/cap_ecg and pend is set.
//   - Input changes after the tick edge never reach RAM.
//   - If a tick arrives while pend is still set: captures are overwritten and overrun_cnt increments
//     (saturates at 255).
//   FSM (IDLE, WR_EMG, WR_ECG)
//   - IDLE, pend=1 -> WR_EMG, with priority over VGA.
//   - IDLE, pend=0, vga_rd_req=1 -> vga_rd_ack=1, ram_addr=vga_rd_addr, ram_we=0.
//     vga_rd_valid=1 on the next cycle.
//   - WR_EMG: ram_we=1, ram_addr=EMG_BASE+emg_head, ram_wdata=cap_emg. emg_head advances. -> WR_ECG.
//   - WR_ECG: ram_we=1, ram_addr=ECG_BASE+ecg_head, ram_wdata=cap_ecg. ecg_head advances.
//     pend clears. -> IDLE.
//   - In write states vga_rd_ack=0. The request waits, so worst-case VGA stall is 2 cycles per tick.
//   - Idle port B: ram_addr holds its last value, ram_we=0.
//   Heads and wrap
//   - Head advance: head==BUF_DEPTH-1 ? 0 : head+1. Address arithmetic is 12-bit, no carry out.
//   - frame_done pulses the cycle after the WR_ECG that wraps ecg_head to 0.
//   Latency
//   - First RAM write occurs 1 cycle after the tick, i.e. cycle SAMPLE_INTERVAL after reset release.
//   Reset mid-operation
//   - Asynchronous reset aborts any write in flight; the second channel of that tick is not written.
//   - Heads return to 0.
// TESTING
//   1 Assert reset mid-run -> all outputs 0 immediately, ram_we=0; no write until SAMPLE_INTERVAL cycles
//     after release.
//   2 SAMPLE_INTERVAL=8, emg_in=32'hAAA, ecg_in=32'h555 -> cycle 8: we=1 addr 12'h400 data AAA;
//     cycle 9: addr 12'h800 data 555; heads=1.
//   3 BUF_DEPTH=4, run 5 ticks -> 4th tick writes 12'h403/12'h803, heads=0, frame_done=1 for one cycle;
//     5th tick writes 12'h400/12'h800.
//   4 Preload RAM[12'h123]=32'hDEAD; hold vga_rd_req with addr 12'h123 across a tick -> ack withheld
//     in WR_EMG/WR_ECG, granted in IDLE; next cycle vga_rd_valid=1, data=DEAD.
//   5 Change emg_in to 32'h111 one cycle after tick -> RAM receives the pre-change value.
//   6 Reset asserted during WR_EMG -> no ECG write, heads=0, overrun_cnt=0.
//   7 Force pend via SAMPLE_INTERVAL=4 with VGA idle -> overrun_cnt stays 0.
//     Stall the FSM through a bench-only hook -> overrun_cnt increments and saturates at 255.

Source files
------------

// File: rtl/biosignal_sample_writer_if.sv
// VGA read channel into the sample writer's RAM port B.
// The display side is the master and the sample writer is the slave.
interface biosignal_sample_writer_if;
  logic        vga_rd_req;
  logic [11:0] vga_rd_addr;
  logic        vga_rd_ack;
  logic        vga_rd_valid;
  logic [31:0] vga_rd_data;

  modport master (
    output vga_rd_req, vga_rd_addr,
    input  vga_rd_ack, vga_rd_valid, vga_rd_data
  );

  modport slave (
    input  vga_rd_req, vga_rd_addr,
    output vga_rd_ack, vga_rd_valid, vga_rd_data
  );
endinterface

// File: rtl/biosignal_sample_writer.sv
// Commits EMG/ECG samples into two circular RAM buffers at a fixed tick rate.
// Owns RAM port B and lets VGA reads through whenever no sample write is pending.
module biosignal_sample_writer #(
  parameter int unsigned SAMPLE_INTERVAL = 175000,
  parameter int unsigned BUF_DEPTH       = 640,
  parameter logic [11:0] EMG_BASE        = 12'h400,
  parameter logic [11:0] ECG_BASE        = 12'h800
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                emg_in,
  input  logic [31:0]                ecg_in,
  biosignal_sample_writer_if.slave   vga,
  output logic                       ram_we,
  output logic [11:0]                ram_addr,
  output logic [31:0]                ram_wdata,
  input  logic [31:0]                ram_rdata,
  output logic [9:0]                 emg_head,
  output logic [9:0]                 ecg_head,
  output logic                       frame_done,
  output logic [7:0]                 overrun_cnt
);

  typedef enum logic [1:0] {IDLE, WR_EMG, WR_ECG} state_t;

  localparam logic [17:0] TICK_LAST = 18'(SAMPLE_INTERVAL - 1);
  localparam logic [9:0]  HEAD_LAST = 10'(BUF_DEPTH - 1);

  state_t      state_q, state_d;
  logic [17:0] tick_cnt_q, tick_cnt_d;
  logic [31:0] cap_emg_q, cap_emg_d;
  logic [31:0] cap_ecg_q, cap_ecg_d;
  logic        pend_q, pend_d;
  logic [7:0]  overrun_q, overrun_d;
  logic [9:0]  emg_head_q, emg_head_d;
  logic [9:0]  ecg_head_q, ecg_head_d;
  logic        frame_done_q, frame_done_d;
  logic        rd_valid_q, rd_valid_d;
  logic [11:0] addr_hold_q, addr_hold_d;
  logic        tick;
  logic        fsm_hold;

  // Freezes the FSM when forced high from a test harness; tied low in silicon.
  assign fsm_hold = 1'b0;

  function automatic logic [9:0] advance(input logic [9:0] head);
    return (head == HEAD_LAST) ? 10'd0 : head + 10'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pend_q || tick) state_d = WR_EMG;
      WR_EMG:  state_d = WR_ECG;
      WR_ECG:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fsm_hold) state_d = state_q;
  end

  // Port B mux: sample writes own the port; VGA only gets it in IDLE with nothing pending.
  always_comb begin
    ram_we         = 1'b0;
    ram_addr       = addr_hold_q;
    ram_wdata      = 32'd0;
    vga.vga_rd_ack = 1'b0;
    unique case (state_q)
      WR_EMG: begin
        ram_we    = 1'b1;
        ram_addr  = EMG_BASE + {2'b00, emg_head_q};
        ram_wdata = cap_emg_q;
      end
      WR_ECG: begin
        ram_we    = 1'b1;
        ram_addr  = ECG_BASE + {2'b00, ecg_head_q};
        ram_wdata = cap_ecg_q;
      end
      default: begin
        if (!pend_q && vga.vga_rd_req) begin
          vga.vga_rd_ack = 1'b1;
          ram_addr       = vga.vga_rd_addr;
        end
      end
    endcase
  end

  always_comb begin
    tick         = (tick_cnt_q == TICK_LAST);
    tick_cnt_d   = tick ? 18'd0 : tick_cnt_q + 18'd1;
    cap_emg_d    = tick ? emg_in : cap_emg_q;
    cap_ecg_d    = tick ? ecg_in : cap_ecg_q;
    pend_d       = pend_q;
    overrun_d    = overrun_q;
    emg_head_d   = emg_head_q;
    ecg_head_d   = ecg_head_q;
    frame_done_d = 1'b0;
    rd_valid_d   = vga.vga_rd_ack;
    addr_hold_d  = ram_addr;
    if (!fsm_hold && state_q == WR_EMG) emg_head_d = advance(emg_head_q);
    if (!fsm_hold && state_q == WR_ECG) begin
      ecg_head_d   = advance(ecg_head_q);
      pend_d       = 1'b0;
      frame_done_d = (ecg_head_q == HEAD_LAST);
    end
    // A new tick always wins over the clear so a back-to-back sample is never lost.
    if (tick) begin
      pend_d = 1'b1;
      if (pend_q && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      cap_emg_q    <= '0;
      cap_ecg_q    <= '0;
      pend_q       <= 1'b0;
      overrun_q    <= '0;
      emg_head_q   <= '0;
      ecg_head_q   <= '0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      addr_hold_q  <= '0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      cap_emg_q    <= cap_emg_d;
      cap_ecg_q    <= cap_ecg_d;
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
      emg_head_q   <= emg_head_d;
      ecg_head_q   <= ecg_head_d;
      frame_done_q <= frame_done_d;
      rd_valid_q   <= rd_valid_d;
      addr_hold_q  <= addr_hold_d;
    end
  end

  assign vga.vga_rd_valid = rd_valid_q;
  assign vga.vga_rd_data  = ram_rdata;
  assign emg_head         = emg_head_q;
  assign ecg_head         = ecg_head_q;
  assign frame_done       = frame_done_q;
  assign overrun_cnt      = overrun_q;

endmodule

// File: tb/tb_biosignal_sample_writer.sv
// Directed bench for biosignal_sample_writer with a small sync RAM model.
// Expected RAM writes and VGA read data are queued at stimulus time and checked by a monitor.
module tb_biosignal_sample_writer;
  localparam int SI = 8;
  localparam int BD = 4;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] emg_in, ecg_in;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [9:0]  emg_head, ecg_head;
  logic        frame_done;
  logic [7:0]  overrun_cnt;
  logic [31:0] mem [0:4095];
  int          cyc;
  int          n_checks = 0;
  int          n_fail = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];

  biosignal_sample_writer_if vga_bus();

  biosignal_sample_writer #(
    .SAMPLE_INTERVAL(SI), .BUF_DEPTH(BD), .EMG_BASE(12'h400), .ECG_BASE(12'h800)
  ) dut (
    .clock(clock), .reset(reset), .emg_in(emg_in), .ecg_in(ecg_in), .vga(vga_bus.slave),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .emg_head(emg_head), .ecg_head(ecg_head), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
  );

  always #5 clock = ~clock;

  // Synchronous read-first RAM; word 12'h123 is reloaded with DEAD while reset is high.
  always @(posedge clock) begin
    if (reset) mem[12'h123] <= 32'h0000DEAD;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] emg, input logic [31:0] ecg,
                               input logic [11:0] emg_addr, input logic [11:0] ecg_addr);
    wr_t w;
    emg_in = emg;
    ecg_in = ecg;
    w.addr = emg_addr; w.data = emg; exp_wr.push_back(w);
    w.addr = ecg_addr; w.data = ecg; exp_wr.push_back(w);
  endtask

  task automatic waitCycle(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != n) checkOutput("wait_cycle_timeout", 32'(cyc), 32'(n));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    checkOutput({tag, "_rd_valid"}, 32'(vga_bus.vga_rd_valid), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun_cnt), 32'd0);
    checkOutput({tag, "_emg_head"}, 32'(emg_head), 32'd0);
    checkOutput({tag, "_ecg_head"}, 32'(ecg_head), 32'd0);
  endtask

  // Releases reset and confirms the first write lands exactly SI cycles later.
  task automatic releaseAndCheckFirstWrite(input string tag);
    int early = 0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    while (cyc < SI) begin
      if (ram_we) early++;
      @(negedge clock);
    end
    checkOutput({tag, "_no_early_write"}, 32'(early), 32'd0);
    checkOutput({tag, "_we_first_write"}, 32'(ram_we), 32'd1);
    @(negedge clock);
    checkOutput({tag, "_we_second_write"}, 32'(ram_we), 32'd1);
    checkOutput({tag, "_emg_head_mid"}, 32'(emg_head), 32'd1);
    @(negedge clock);
    checkOutput({tag, "_we_after"}, 32'(ram_we), 32'd0);
    checkOutput({tag, "_emg_head"}, 32'(emg_head), 32'd1);
    checkOutput({tag, "_ecg_head"}, 32'(ecg_head), 32'd1);
  endtask

  initial begin : monitor
    wr_t w;
    logic [31:0] d;
    forever begin
      @(negedge clock);
      if (ram_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_write: addr %h data %h, expected no write", ram_addr, ram_wdata);
        end else begin
          w = exp_wr.pop_front();
          checkOutput("wr_addr", 32'(ram_addr), 32'(w.addr));
          checkOutput("wr_data", ram_wdata, w.data);
        end
      end
      if (vga_bus.vga_rd_valid) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_rd_valid: data %h, expected no read", vga_bus.vga_rd_data);
        end else begin
          d = exp_rd.pop_front();
          checkOutput("rd_data", vga_bus.vga_rd_data, d);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    emg_in = '0;
    ecg_in = '0;
    vga_bus.vga_rd_req = 1'b0;
    vga_bus.vga_rd_addr = '0;
    repeat (3) @(negedge clock);
    checkResetOutputs("por");

    applyStimulus(32'hAAA, 32'h555, 12'h400, 12'h800);
    releaseAndCheckFirstWrite("first");

    // Inputs change right after the capture edge; RAM must see the captured values.
    waitCycle(12);
    applyStimulus(32'h222, 32'h333, 12'h401, 12'h801);
    waitCycle(16);
    emg_in = 32'h111;
    ecg_in = 32'h999;

    waitCycle(20);
    applyStimulus(32'h303, 32'h3C3, 12'h402, 12'h802);
    waitCycle(28);
    applyStimulus(32'h404, 32'h4C4, 12'h403, 12'h803);
    waitCycle(33);
    checkOutput("frame_done_c33", 32'(frame_done), 32'd0);
    waitCycle(34);
    checkOutput("frame_done_c34", 32'(frame_done), 32'd1);
    checkOutput("emg_head_wrap", 32'(emg_head), 32'd0);
    checkOutput("ecg_head_wrap", 32'(ecg_head), 32'd0);
    waitCycle(35);
    checkOutput("frame_done_c35", 32'(frame_done), 32'd0);
    waitCycle(36);
    applyStimulus(32'h505, 32'h5C5, 12'h400, 12'h800);
    waitCycle(42);
    checkOutput("emg_head_t5", 32'(emg_head), 32'd1);
    checkOutput("ecg_head_t5", 32'(ecg_head), 32'd1);
    checkOutput("overrun_normal", 32'(overrun_cnt), 32'd0);

    // VGA request raised while the tick's writes own the port.
    waitCycle(44);
    applyStimulus(32'h606, 32'h6C6, 12'h401, 12'h801);
    waitCycle(48);
    vga_bus.vga_rd_req = 1'b1;
    vga_bus.vga_rd_addr = 12'h123;
    exp_rd.push_back(32'h0000DEAD);
    #1;
    checkOutput("ack_wr_emg", 32'(vga_bus.vga_rd_ack), 32'd0);
    @(negedge clock);
    checkOutput("ack_wr_ecg", 32'(vga_bus.vga_rd_ack), 32'd0);
    @(negedge clock);
    checkOutput("ack_idle", 32'(vga_bus.vga_rd_ack), 32'd1);
    checkOutput("rd_addr", 32'(ram_addr), 32'h123);
    checkOutput("rd_we", 32'(ram_we), 32'd0);
    @(posedge clock);
    #1 vga_bus.vga_rd_req = 1'b0;
    @(negedge clock);
    checkOutput("rd_valid", 32'(vga_bus.vga_rd_valid), 32'd1);
    checkOutput("addr_hold", 32'(ram_addr), 32'h123);
    @(negedge clock);
    checkOutput("rd_valid_drop", 32'(vga_bus.vga_rd_valid), 32'd0);

    // Reset lands inside WR_EMG of the next tick: neither channel may reach RAM.
    emg_in = 32'h707;
    ecg_in = 32'h7C7;
    waitCycle(55);
    @(posedge clock);
    #1 reset = 1'b1;
    #1 checkResetOutputs("midrun");
    repeat (2) @(negedge clock);
    checkOutput("ecg_not_written", mem[12'h802], 32'h3C3);
    checkOutput("emg_not_written", mem[12'h402], 32'h303);
    applyStimulus(32'h808, 32'h8C8, 12'h400, 12'h800);
    releaseAndCheckFirstWrite("rerun");

    // Stall the FSM so pending samples pile up into overruns.
    waitCycle(12);
    force dut.fsm_hold = 1'b1;
    emg_in = 32'h909;
    ecg_in = 32'h9C9;
    waitCycle(24);
    checkOutput("overrun_first", 32'(overrun_cnt), 32'd1);
    waitCycle(2048);
    checkOutput("overrun_254", 32'(overrun_cnt), 32'd254);
    waitCycle(2056);
    checkOutput("overrun_255", 32'(overrun_cnt), 32'd255);
    waitCycle(2200);
    checkOutput("overrun_sat", 32'(overrun_cnt), 32'd255);
    @(posedge clock);
    #1 reset = 1'b1;
    release dut.fsm_hold;
    #1 checkResetOutputs("final");
    repeat (3) @(negedge clock);
    checkOutput("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    checkOutput("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
